// File: rtl/mem_dot_sched.sv
// rtl/mem_dot_sched.sv - single-port memory scheduler shared by host and a dot-product engine
// Optional SCHED_SIGNED_EN: treat operands as two's complement and sign-extend the products.
module mem_dot_sched #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              start,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W:0]   len,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE_A, S_ISSUE_B, S_MAC, S_WR_LO, S_WR_HI, S_DONE
  } state_t;

  localparam logic [ADDR_W:0]   ONE_I = 1;
  localparam logic [ADDR_W-1:0] ONE_A = 1;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d, result_q, prod;
  logic [ADDR_W:0]     i_q, i_d, len_q, i_inc;
  logic [ADDR_W-1:0]   a_base_q, b_base_q, dst_q;
  logic [DATA_W-1:0]   a_q, b_op;
  logic [ACC_W-1:0]    a_ext, b_ext;
  logic                pend_a_q, pend_b_q, host_rvalid_q;
  logic                launch, eng_req, eng_we, eng_gnt;
  logic [ADDR_W-1:0]   eng_addr;
  logic [DATA_W-1:0]   eng_wdata;

  // B data arrives on mem_rdata exactly in the MAC cycle, so it is used unregistered.
  assign b_op  = pend_b_q ? mem_rdata : '0;
  assign i_inc = i_q + ONE_I;
`ifdef SCHED_SIGNED_EN
  assign a_ext = {{(ACC_W-DATA_W){a_q[DATA_W-1]}}, a_q};
  assign b_ext = {{(ACC_W-DATA_W){b_op[DATA_W-1]}}, b_op};
`else
  assign a_ext = {{(ACC_W-DATA_W){1'b0}}, a_q};
  assign b_ext = {{(ACC_W-DATA_W){1'b0}}, b_op};
`endif
  assign prod = a_ext * b_ext;

  always_comb begin
    eng_req   = 1'b0;
    eng_we    = 1'b0;
    eng_addr  = '0;
    eng_wdata = '0;
    case (state_q)
      S_ISSUE_A: begin eng_req = 1'b1; eng_addr = a_base_q + i_q[ADDR_W-1:0]; end
      S_ISSUE_B: begin eng_req = 1'b1; eng_addr = b_base_q + i_q[ADDR_W-1:0]; end
      S_WR_LO: begin
        eng_req = 1'b1; eng_we = 1'b1; eng_addr = dst_q; eng_wdata = acc_q[DATA_W-1:0];
      end
      S_WR_HI: begin
        eng_req = 1'b1; eng_we = 1'b1; eng_addr = dst_q + ONE_A;
        eng_wdata = acc_q[ACC_W-1:DATA_W];
      end
      default: ;
    endcase
  end

  // Host always wins; reset also blocks the engine so an abort issues no stray write.
  assign eng_gnt = eng_req & ~host_valid & ~reset;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (host_valid) begin
      mem_addr = host_addr; mem_we = host_we; mem_wdata = host_wdata;
    end else if (eng_gnt) begin
      mem_addr = eng_addr; mem_we = eng_we; mem_wdata = eng_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    i_d     = i_q;
    launch  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        launch  = 1'b1;
        acc_d   = '0;
        i_d     = '0;
        state_d = (len == '0) ? S_WR_LO : S_ISSUE_A;
      end
      S_ISSUE_A: if (eng_gnt) state_d = S_ISSUE_B;
      S_ISSUE_B: if (eng_gnt) state_d = S_MAC;
      S_MAC: begin
        acc_d   = acc_q + prod;
        i_d     = i_inc;
        state_d = (i_inc == len_q) ? S_WR_LO : S_ISSUE_A;
      end
      S_WR_LO: if (eng_gnt) state_d = S_WR_HI;
      S_WR_HI: if (eng_gnt) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      i_q           <= '0;
      len_q         <= '0;
      a_base_q      <= '0;
      b_base_q      <= '0;
      dst_q         <= '0;
      a_q           <= '0;
      pend_a_q      <= 1'b0;
      pend_b_q      <= 1'b0;
      result_q      <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      i_q           <= i_d;
      host_rvalid_q <= host_valid & ~host_we;
      pend_a_q      <= (state_q == S_ISSUE_A) & eng_gnt;
      pend_b_q      <= (state_q == S_ISSUE_B) & eng_gnt;
      if (pend_a_q) a_q <= mem_rdata;
      if (launch) begin
        len_q    <= len;
        a_base_q <= a_base;
        b_base_q <= b_base;
        dst_q    <= dst_addr;
      end
      // Published on the last write grant so it is visible in the same cycle as done.
      if ((state_q == S_WR_HI) && eng_gnt) result_q <= acc_q;
    end
  end

  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = mem_rdata;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign result      = result_q;

endmodule

// File: tb/tb_mem_dot_sched.sv
// tb/tb_mem_dot_sched.sv - self-checking bench for mem_dot_sched with a behavioural memory
module tb_mem_dot_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       host_valid = 1'b0, host_we = 1'b0;
  logic [2:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_rvalid;
  logic [7:0] host_rdata;
  logic       start = 1'b0;
  logic [2:0] a_base = '0, b_base = '0, dst_addr = '0;
  logic [3:0] len = '0;
  logic       busy, done;
  logic [15:0] result;
  logic [2:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;

  logic [7:0] mem [8];
  int checks = 0;
  int errors = 0;
  int we_count = 0;
  logic [7:0]  rd_q[$];
  logic [15:0] res_q[$];
  int          cyc_q[$];

  mem_dot_sched dut (
    .clk(clk), .reset(reset),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .start(start), .a_base(a_base), .b_base(b_base), .len(len), .dst_addr(dst_addr),
    .busy(busy), .done(done), .result(result),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial for (int k = 0; k < 8; k++) mem[k] = 8'h00;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_count = we_count + 1;
    end
    mem_rdata <= mem[mem_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    host_valid = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_valid = 1'b0; host_we = 1'b0;
  endtask

  task automatic load8(input logic [63:0] v);
    for (int k = 0; k < 8; k++) host_write(3'(k), v[k*8 +: 8]);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", host_rvalid); end
    checks++; if (result !== 16'h0) begin errors++; $display("FAIL reset_result got %h want 0000", result); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    checks++; if (mem_addr !== 3'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 8'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 00", mem_wdata); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_host_rw;
    for (int k = 0; k < 8; k++) host_write(3'(k), 8'h11 + 8'(k));
    // back-to-back reads, one per cycle
    for (int k = 0; k < 8; k++) begin
      host_valid = 1'b1; host_we = 1'b0; host_addr = 3'(k);
      rd_q.push_back(8'h11 + 8'(k));
      tick();
      checks++;
      if (host_rvalid !== 1'b1) begin
        errors++; $display("FAIL host_rvalid[%0d] got %b want 1", k, host_rvalid);
        void'(rd_q.pop_front());
      end else begin
        logic [7:0] e;
        e = rd_q.pop_front();
        checks++;
        if (host_rdata !== e) begin errors++; $display("FAIL host_rdata[%0d] got %h want %h", k, host_rdata, e); end
      end
    end
    host_valid = 1'b0;
    tick();
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL host_rvalid_idle got %b want 0", host_rvalid); end
  endtask

  task automatic run_dot(input string name, input logic [2:0] a, input logic [2:0] b,
                         input logic [3:0] n, input logic [2:0] dst,
                         input int stall_at, input int stall_n,
                         input logic [15:0] exp_res, input int exp_cyc);
    int c;
    logic [15:0] er;
    int ec;
    logic [2:0] hi_a;
    res_q.push_back(exp_res);
    cyc_q.push_back(exp_cyc);
    a_base = a; b_base = b; len = n; dst_addr = dst;
    start = 1'b1; c = 0;
    host_valid = (stall_n > 0 && stall_at == 0); host_we = 1'b0; host_addr = 3'd5;
    do begin
      tick(); c++;
      start = 1'b0;
      host_valid = (c >= stall_at) && (c < stall_at + stall_n);
      if (c == 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy got %b want 1", name, busy); end
      end
    end while (done !== 1'b1 && c < 200);
    host_valid = 1'b0;
    er = res_q.pop_front();
    ec = cyc_q.pop_front();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL %s_timeout no done within %0d cycles", name, c);
    end else begin
      if (c !== ec) begin errors++; $display("FAIL %s_done_cycle got %0d want %0d", name, c, ec); end
      checks++; if (result !== er) begin errors++; $display("FAIL %s_result got %h want %h", name, result, er); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_done got %b want 0", name, busy); end
    end
    tick();
    hi_a = dst + 3'd1;
    checks++; if (mem[dst] !== er[7:0]) begin errors++; $display("FAIL %s_mem_lo got %h want %h", name, mem[dst], er[7:0]); end
    checks++; if (mem[hi_a] !== er[15:8]) begin errors++; $display("FAIL %s_mem_hi got %h want %h", name, mem[hi_a], er[15:8]); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got %b want 0", name, done); end
  endtask

  task automatic test_vector_sum;
    load8(64'h0807060504030201);
    run_dot("vsum", 3'd0, 3'd4, 4'd4, 3'd6, 0, 0, 16'd70, 15);
  endtask

  task automatic test_wrap;
    load8(64'hFFFFFFFFFFFFFFFF);
    run_dot("wrap", 3'd0, 3'd0, 4'd8, 3'd7, 0, 0, 16'hF008, 27);
  endtask

  task automatic test_len_zero;
    host_write(3'd2, 8'hAA);
    host_write(3'd3, 8'hAA);
    run_dot("len0", 3'd0, 3'd0, 4'd0, 3'd2, 0, 0, 16'h0000, 3);
  endtask

  task automatic test_host_stall;
    load8(64'h0807060504030201);
    run_dot("stall", 3'd0, 3'd4, 4'd4, 3'd6, 2, 5, 16'd70, 20);
  endtask

  task automatic test_signed;
    host_write(3'd0, 8'hFF);
    host_write(3'd1, 8'h02);
`ifdef SCHED_SIGNED_EN
    run_dot("sign", 3'd0, 3'd1, 4'd1, 3'd4, 0, 0, 16'hFFFE, 6);
`else
    run_dot("sign", 3'd0, 3'd1, 4'd1, 3'd4, 0, 0, 16'h01FE, 6);
`endif
  endtask

  task automatic test_reset_mid;
    int snap;
    load8(64'h0807060504030201);
    a_base = 3'd0; b_base = 3'd4; len = 4'd4; dst_addr = 3'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    snap = we_count;
    for (int k = 0; k < 20; k++) tick();
    checks++; if (we_count !== snap) begin errors++; $display("FAIL rst_mid_writes got %0d want 0", we_count - snap); end
    checks++; if (mem[6] !== 8'h07) begin errors++; $display("FAIL rst_mid_mem6 got %h want 07", mem[6]); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b want 0", done); end
  endtask

  initial begin
    test_reset();
    test_host_rw();
    test_vector_sum();
    test_wrap();
    test_len_zero();
    test_host_stall();
    test_signed();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
